snitch_icache_data_ctrl: RTL and testbench
==========================================

SNITCH_ICACHE_DATA_CTRL -- requirements
Module: snitch_icache_data_ctrl

Interface
REQ-001 SHALL have parameter CFG, default '0: snitch_icache_pkg::config_t; supplies SET_COUNT, LINE_COUNT, LINE_WIDTH and COUNT_ALIGN.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive write-blocked lookup cycles before a lookup is forced through; legal range 1..255.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have lookup ports: lookup_req_i  in  1  read request; lookup_addr_i  in  COUNT_ALIGN  line index; lookup_set_i  in  $clog2(SET_COUNT)  way index; lookup_gnt_o  out  1  read accepted.
REQ-005 SHALL have response ports: rsp_data_o  out  LINE_WIDTH  line data; rsp_valid_o  out  1  data valid; rsp_ready_i  in  1  consumer accepts.
REQ-006 SHALL have refill ports: write_req_i  in  1  write request; write_addr_i  in  COUNT_ALIGN  line index; write_set_i  in  SET_COUNT  one-hot way mask; write_data_i  in  LINE_WIDTH  line data; write_gnt_o  out  1  write accepted.
REQ-007 SHALL have SRAM ports: ram_enable_o  out  SET_COUNT  per-set enable; ram_write_o  out  1  write strobe; ram_addr_o  out  COUNT_ALIGN  address; ram_wdata_o  out  SET_COUNT x LINE_WIDTH  write data, replicated per set; ram_rdata_i  in  SET_COUNT x LINE_WIDTH  read data, 1-cycle latency.
REQ-008 SHALL have busy_o  out  1  controller in init sweep.

Function
REQ-009 SHALL issue at most one SRAM access per cycle; the SRAM is single-port.
REQ-010 SHALL define stall = rsp_valid_o AND NOT rsp_ready_i; no lookup is granted while stall is high.
REQ-011 SHALL grant a write whenever write_req_i is high in IDLE, unless a forced lookup applies (REQ-012).
REQ-012 SHALL count consecutive cycles with lookup_req_i high, no stall and write_gnt_o high; when the count equals STARVE_MAX and lookup_req_i is high without stall, grant the lookup, withhold write_gnt_o and clear the count.
REQ-013 SHALL clear the starvation count on any lookup grant and on any cycle without lookup_req_i.
REQ-014 SHALL grant a lookup combinationally when lookup_req_i is high, stall is low and no write is granted.
REQ-015 On a lookup grant, SHALL drive ram_enable_o one-hot at lookup_set_i, ram_write_o=0 and ram_addr_o=lookup_addr_i, and register the set index.
REQ-016 On a write grant, SHALL drive ram_enable_o=write_set_i, ram_write_o=1, ram_addr_o=write_addr_i and ram_wdata_o=write_data_i replicated per set.
REQ-017 With no grant, SHALL drive ram_enable_o=0; ram_write_o and ram_addr_o are don't-care.
REQ-018 SHALL assert rsp_valid_o in the cycle after a lookup grant, with rsp_data_o = ram_rdata_i[registered set].
REQ-019 If rsp_valid_o is high and rsp_ready_i is low, SHALL capture the data into a hold register and present it until accepted; rsp_data_o SHALL stay stable while stalled.
REQ-020 SHALL deassert rsp_valid_o on the cycle after a handshake unless a new lookup was granted in the handshake cycle, allowing back-to-back responses at one per cycle.
REQ-021 A same-cycle write and lookup to the same address: the winner per REQ-011/012 proceeds; a granted lookup returns pre-write content, with no write bypass.
REQ-022 SHALL ignore lookup_req_i and write_req_i when the matching grant is low; requesters hold request and payload until granted.

Reset
REQ-023 Asynchronous reset SHALL force rsp_valid_o=0, the hold register valid flag=0, the starvation count=0 and ram_enable_o=0.
REQ-024 After reset, the initial state SHALL follow REQ-026/027.
REQ-025 A reset during a pending response SHALL discard it; no rsp_valid_o pulse follows reset release.

Configuration
REQ-026 With SNITCH_ICACHE_DATA_INIT_EN defined, the FSM SHALL have states INIT and IDLE:
- INIT after reset; writes zero to all sets at addresses 0..LINE_COUNT-1, one per cycle, with ram_enable_o all ones.
- busy_o=1 and both grants 0 throughout INIT.
- Enters IDLE after address LINE_COUNT-1; busy_o drops in the first IDLE cycle.
REQ-027 Without SNITCH_ICACHE_DATA_INIT_EN, SHALL reset directly into IDLE with busy_o tied 0 and no INIT state.

Verification
REQ-028 Lookup only: addr=5, set=1, rsp_ready_i=1 -> gnt same cycle, ram_enable_o=0b0010, rsp_valid_o next cycle with ram_rdata_i[1].
REQ-029 Backpressure: rsp_ready_i=0 for 3 cycles with lookup_req_i held -> rsp_data_o stable, lookup_gnt_o=0 for those 3 cycles, then one handshake.
REQ-030 Contention: write_req_i and lookup_req_i both held, STARVE_MAX=4 -> 4 write grants, then 1 lookup grant; pattern repeats.
REQ-031 Same-address collision: memory holds 0xA at addr 3; forced lookup and write 0xB to addr 3 together -> response returns 0xA; a later read returns 0xB.
REQ-032 Reset mid-read: assert rst_ni low in the cycle after a grant -> no rsp_valid_o pulse.
REQ-032 (cont.) With SNITCH_ICACHE_DATA_INIT_EN, LINE_COUNT=128 -> busy_o high for exactly 128 cycles, all lines read back zero.

Source files
------------

// File: rtl/snitch_icache_data_ctrl_if.sv
// Bus bundle for the icache data-array controller: lookup, response, refill
// and single-port SRAM signals. The slave modport is the controller's view;
// the master modport is the view of the environment driving it.
interface snitch_icache_data_ctrl_if #(
  parameter int unsigned SET_COUNT   = 4,
  parameter int unsigned LINE_WIDTH  = 32,
  parameter int unsigned COUNT_ALIGN = 7,
  parameter int unsigned SET_W       = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1
);
  // lookup request
  logic                                   lookup_req_i;
  logic [COUNT_ALIGN-1:0]                 lookup_addr_i;
  logic [SET_W-1:0]                       lookup_set_i;
  logic                                   lookup_gnt_o;
  // read response
  logic [LINE_WIDTH-1:0]                  rsp_data_o;
  logic                                   rsp_valid_o;
  logic                                   rsp_ready_i;
  // refill write
  logic                                   write_req_i;
  logic [COUNT_ALIGN-1:0]                 write_addr_i;
  logic [SET_COUNT-1:0]                   write_set_i;
  logic [LINE_WIDTH-1:0]                  write_data_i;
  logic                                   write_gnt_o;
  // SRAM port
  logic [SET_COUNT-1:0]                   ram_enable_o;
  logic                                   ram_write_o;
  logic [COUNT_ALIGN-1:0]                 ram_addr_o;
  logic [SET_COUNT-1:0][LINE_WIDTH-1:0]   ram_wdata_o;
  logic [SET_COUNT-1:0][LINE_WIDTH-1:0]   ram_rdata_i;
  // status
  logic                                   busy_o;

  modport slave (
    input  lookup_req_i, lookup_addr_i, lookup_set_i, rsp_ready_i,
    input  write_req_i, write_addr_i, write_set_i, write_data_i, ram_rdata_i,
    output lookup_gnt_o, rsp_data_o, rsp_valid_o, write_gnt_o,
    output ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o, busy_o
  );

  modport master (
    output lookup_req_i, lookup_addr_i, lookup_set_i, rsp_ready_i,
    output write_req_i, write_addr_i, write_set_i, write_data_i, ram_rdata_i,
    input  lookup_gnt_o, rsp_data_o, rsp_valid_o, write_gnt_o,
    input  ram_enable_o, ram_write_o, ram_addr_o, ram_wdata_o, busy_o
  );
endinterface

// File: rtl/snitch_icache_data_ctrl.sv
// Icache data-array controller. Arbitrates one single-port SRAM between
// cache lookups and refill writes, with a starvation counter that forces a
// lookup through after STARVE_MAX consecutive write-blocked cycles, and a
// response stage with a hold register for consumer backpressure.
// Optional feature macro: SNITCH_ICACHE_DATA_INIT_EN -- when defined, the
// controller sweeps zeros into every line of every set after reset (busy_o
// high) before it accepts any request.
package snitch_icache_pkg;
  typedef struct packed {
    logic [31:0] SET_COUNT;
    logic [31:0] LINE_COUNT;
    logic [31:0] LINE_WIDTH;
    logic [31:0] COUNT_ALIGN;
  } config_t;
endpackage

module snitch_icache_data_ctrl #(
  parameter snitch_icache_pkg::config_t CFG = '0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  snitch_icache_data_ctrl_if.slave   bus
);
  // An all-zero configuration falls back to minimal legal widths.
  localparam int unsigned SET_COUNT   = (CFG.SET_COUNT   == 0) ? 1 : CFG.SET_COUNT;
  localparam int unsigned LINE_WIDTH  = (CFG.LINE_WIDTH  == 0) ? 1 : CFG.LINE_WIDTH;
  localparam int unsigned COUNT_ALIGN = (CFG.COUNT_ALIGN == 0) ? 1 : CFG.COUNT_ALIGN;
  localparam int unsigned SET_W       = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;

  logic                   busy;
  logic                   idle;
  logic [COUNT_ALIGN-1:0] sweep_addr;

  logic                   stall;
  logic                   force_lookup;
  logic                   lookup_gnt;
  logic                   write_gnt;
  logic [7:0]             starve_cnt;

  logic                   rsp_valid;
  logic                   hold_valid;
  logic [SET_W-1:0]       set_q;
  logic [LINE_WIDTH-1:0]  hold_data;

`ifdef SNITCH_ICACHE_DATA_INIT_EN
  localparam int unsigned LINE_COUNT = (CFG.LINE_COUNT == 0) ? 1 : CFG.LINE_COUNT;

  typedef enum logic {INIT, IDLE} state_e;
  state_e                 state_q;
  state_e                 state_d;
  logic [COUNT_ALIGN-1:0] init_addr_q;
  logic                   init_last;

  assign init_last  = (init_addr_q == COUNT_ALIGN'(LINE_COUNT - 1));
  assign sweep_addr = init_addr_q;

  // State register: every reset restarts the zeroing sweep.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= INIT;
    else         state_q <= state_d;
  end

  // Next state: leave INIT once the last line has been written.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_last) state_d = IDLE;
  end

  // State outputs: busy during the sweep, requests served only in IDLE.
  always_comb begin
    busy = (state_q == INIT);
    idle = (state_q == IDLE);
  end

  // Sweep address walks 0..LINE_COUNT-1, one line per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   init_addr_q <= '0;
    else if (busy) init_addr_q <= init_addr_q + COUNT_ALIGN'(1);
  end
`else
  assign busy       = 1'b0;
  assign idle       = 1'b1;
  assign sweep_addr = '0;
`endif

  // Arbitration: writes win by default, a starved lookup wins once.
  assign stall        = rsp_valid & ~bus.rsp_ready_i;
  assign force_lookup = idle & bus.lookup_req_i & ~stall & (starve_cnt == 8'(STARVE_MAX));
  assign write_gnt    = idle & bus.write_req_i & ~force_lookup;
  assign lookup_gnt   = idle & bus.lookup_req_i & ~stall & ~write_gnt;

  // Starvation count: consecutive cycles a ready lookup lost to a write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                            starve_cnt <= '0;
    else if (lookup_gnt || !bus.lookup_req_i) starve_cnt <= '0;
    else if (!stall && write_gnt)           starve_cnt <= starve_cnt + 8'd1;
  end

  // Response control: valid follows a grant and persists while stalled;
  // the hold flag marks that the SRAM output has been captured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid  <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      rsp_valid  <= lookup_gnt | stall;
      hold_valid <= stall;
    end
  end

  // Response data: remember the granted set and freeze SRAM data on the
  // first stalled cycle, since later SRAM cycles may be used by writes.
  always_ff @(posedge clk_i) begin
    if (lookup_gnt)          set_q     <= bus.lookup_set_i;
    if (stall && !hold_valid) hold_data <= bus.ram_rdata_i[set_q];
  end

  assign bus.rsp_valid_o  = rsp_valid;
  assign bus.rsp_data_o   = hold_valid ? hold_data : bus.ram_rdata_i[set_q];
  assign bus.lookup_gnt_o = lookup_gnt;
  assign bus.write_gnt_o  = write_gnt;
  assign bus.busy_o       = busy;

  // SRAM port: at most one access per cycle (sweep, write or read); the
  // enables are held off while reset is asserted.
  always_comb begin
    bus.ram_enable_o = '0;
    bus.ram_write_o  = 1'b0;
    bus.ram_addr_o   = '0;
    for (int s = 0; s < SET_COUNT; s++) bus.ram_wdata_o[s] = bus.write_data_i;
    if (busy) begin
      bus.ram_enable_o = '1;
      bus.ram_write_o  = 1'b1;
      bus.ram_addr_o   = sweep_addr;
      bus.ram_wdata_o  = '0;
    end else if (write_gnt) begin
      bus.ram_enable_o = bus.write_set_i;
      bus.ram_write_o  = 1'b1;
      bus.ram_addr_o   = bus.write_addr_i;
    end else if (lookup_gnt) begin
      bus.ram_enable_o[bus.lookup_set_i] = 1'b1;
      bus.ram_addr_o   = bus.lookup_addr_i;
    end
    if (!rst_ni) bus.ram_enable_o = '0;
  end
endmodule

// File: tb/tb_snitch_icache_data_ctrl.sv
// Bench for snitch_icache_data_ctrl: an SRAM model, a cycle-level reference
// model (reference memory + response queue + starvation rule) checked on
// every cycle, and directed scenarios with literal expectations.
module tb_snitch_icache_data_ctrl;
  localparam int SC = 4, LC = 128, LW = 32, CA = 7, SMAX = 4;
`ifdef SNITCH_ICACHE_DATA_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  localparam snitch_icache_pkg::config_t CFG =
    '{SET_COUNT: 32'd4, LINE_COUNT: 32'd128, LINE_WIDTH: 32'd32, COUNT_ALIGN: 32'd7};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  snitch_icache_data_ctrl_if #(.SET_COUNT(SC), .LINE_WIDTH(LW), .COUNT_ALIGN(CA)) bus ();

  snitch_icache_data_ctrl #(.CFG(CFG), .STARVE_MAX(SMAX)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  function automatic logic [LW-1:0] pat(int s, int a);
    return LW'((s + 1) << 24) | LW'(a);
  endfunction

  function automatic logic [LW-1:0] lit(logic [LW-1:0] v);
    return INIT_EN ? '0 : v;
  endfunction

  // SRAM model: 1-cycle read latency, garbage on idle/written sets.
  logic [LW-1:0] mem [SC][LC];
  logic mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int s = 0; s < SC; s++)
        for (int a = 0; a < LC; a++) mem[s][a] <= pat(s, a);
      mem_loaded <= 1'b1;
    end
    for (int s = 0; s < SC; s++) begin
      if (bus.ram_enable_o[s] && bus.ram_write_o) mem[s][bus.ram_addr_o] <= bus.ram_wdata_o[s];
      if (bus.ram_enable_o[s] && !bus.ram_write_o) bus.ram_rdata_i[s] <= mem[s][bus.ram_addr_o];
      else bus.ram_rdata_i[s] <= LW'($urandom);
    end
  end

  // Reference model state
  logic [LW-1:0] ref_mem [SC][LC];
  logic [LW-1:0] expq [$];
  int ws_run = 0;
  int init_idx = 0;
  bit ref_loaded = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic stall_m, forced, exp_w, exp_l;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        expq.delete();
        ws_run   = 0;
        init_idx = 0;
        if (!ref_loaded || INIT_EN) begin
          for (int s = 0; s < SC; s++)
            for (int a = 0; a < LC; a++) ref_mem[s][a] = INIT_EN ? '0 : pat(s, a);
          ref_loaded = 1'b1;
        end
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_ram_enable", bus.ram_enable_o, 0);
      end else begin
`ifdef SNITCH_ICACHE_DATA_INIT_EN
        chk("busy", bus.busy_o, init_idx < LC);
        if (init_idx < LC) begin
          chk("sweep_enable", bus.ram_enable_o, {SC{1'b1}});
          chk("sweep_write", bus.ram_write_o, 1);
          chk("sweep_addr", bus.ram_addr_o, init_idx);
          chk("sweep_wdata", bus.ram_wdata_o, 0);
          chk("sweep_grants", {bus.lookup_gnt_o, bus.write_gnt_o}, 0);
          chk("sweep_rsp_valid", bus.rsp_valid_o, 0);
          init_idx++;
          continue;
        end
`else
        chk("busy_tied", bus.busy_o, 0);
`endif
        // response side
        chk("rsp_valid", bus.rsp_valid_o, expq.size() != 0);
        if (expq.size() != 0) chk("rsp_data", bus.rsp_data_o, expq[0]);
        stall_m = (expq.size() != 0) && !bus.rsp_ready_i;
        if (expq.size() != 0 && bus.rsp_ready_i) void'(expq.pop_front());
        // arbitration rules
        forced = bus.lookup_req_i && !stall_m && (ws_run == SMAX);
        exp_w  = bus.write_req_i && !forced;
        exp_l  = bus.lookup_req_i && !stall_m && !exp_w;
        chk("write_gnt", bus.write_gnt_o, exp_w);
        chk("lookup_gnt", bus.lookup_gnt_o, exp_l);
        if (exp_w) begin
          chk("wr_enable", bus.ram_enable_o, bus.write_set_i);
          chk("wr_strobe", bus.ram_write_o, 1);
          chk("wr_addr", bus.ram_addr_o, bus.write_addr_i);
          chk("wr_wdata", bus.ram_wdata_o, {SC{bus.write_data_i}});
          for (int s = 0; s < SC; s++)
            if (bus.write_set_i[s]) ref_mem[s][bus.write_addr_i] = bus.write_data_i;
        end else if (exp_l) begin
          chk("rd_enable", bus.ram_enable_o, SC'(1) << bus.lookup_set_i);
          chk("rd_strobe", bus.ram_write_o, 0);
          chk("rd_addr", bus.ram_addr_o, bus.lookup_addr_i);
          expq.push_back(ref_mem[bus.lookup_set_i][bus.lookup_addr_i]);
        end else begin
          chk("no_access_enable", bus.ram_enable_o, 0);
        end
        if (!bus.lookup_req_i || exp_l) ws_run = 0;
        else if (!stall_m && exp_w)     ws_run++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init();
`ifdef SNITCH_ICACHE_DATA_INIT_EN
    int n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus.busy_o) n++;
      else break;
    end
    chk("init_busy_cycles", n, LC);
`else
    @(negedge clk);
    chk("busy_after_reset", bus.busy_o, 0);
`endif
  endtask

  task automatic directed();
    logic [LW-1:0] d0;
    logic [9:0] gl, gw;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid_lit", bus.rsp_valid_o, 0);
    cyc();
    rst_ni = 1'b1;
    wait_init();

`ifdef SNITCH_ICACHE_DATA_INIT_EN
    // every line reads back zero after the sweep
    for (int a = 0; a < LC; a++) begin
      cyc();
      bus.lookup_req_i = 1'b1; bus.lookup_addr_i = CA'(a); bus.lookup_set_i = 2'(a % SC);
      @(negedge clk);
      chk("init_readback_gnt", bus.lookup_gnt_o, 1);
      if (a > 0) chk("init_readback_zero", bus.rsp_data_o, 0);
    end
    cyc();
    bus.lookup_req_i = 1'b0;
    @(negedge clk);
    chk("init_readback_last", bus.rsp_data_o, 0);
`endif

    // lookup only: addr 5, set 1
    cyc();
    bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 7'd5; bus.lookup_set_i = 2'd1;
    @(negedge clk);
    chk("lk_gnt", bus.lookup_gnt_o, 1);
    chk("lk_enable", bus.ram_enable_o, 4'b0010);
    cyc();
    bus.lookup_req_i = 1'b0;
    @(negedge clk);
    chk("lk_rsp_valid", bus.rsp_valid_o, 1);
    chk("lk_rsp_data", bus.rsp_data_o, lit(32'h0200_0005));

    // backpressure: 3 stalled cycles with the next lookup held
    cyc();
    bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 7'd7; bus.lookup_set_i = 2'd0;
    @(negedge clk);
    chk("bp_first_gnt", bus.lookup_gnt_o, 1);
    cyc();
    bus.lookup_addr_i = 7'd8; bus.lookup_set_i = 2'd3; bus.rsp_ready_i = 1'b0;
    @(negedge clk);
    d0 = bus.rsp_data_o;
    chk("bp_valid", bus.rsp_valid_o, 1);
    chk("bp_gnt0", bus.lookup_gnt_o, 0);
    chk("bp_data0", d0, lit(32'h0100_0007));
    cyc();
    bus.write_req_i = 1'b1; bus.write_addr_i = 7'd9; bus.write_set_i = 4'b0001;
    bus.write_data_i = 32'h0000_1234;
    @(negedge clk);
    chk("bp_gnt1", bus.lookup_gnt_o, 0);
    chk("bp_write_during_stall", bus.write_gnt_o, 1);
    chk("bp_data1", bus.rsp_data_o, d0);
    cyc();
    bus.write_req_i = 1'b0;
    @(negedge clk);
    chk("bp_gnt2", bus.lookup_gnt_o, 0);
    chk("bp_data2", bus.rsp_data_o, d0);
    cyc();
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_handshake_gnt", bus.lookup_gnt_o, 1);
    chk("bp_handshake_data", bus.rsp_data_o, d0);
    cyc();
    bus.lookup_req_i = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", bus.rsp_valid_o, 1);
    chk("bp_next_data", bus.rsp_data_o, lit(32'h0400_0008));
    cyc();
    @(negedge clk);
    chk("bp_idle_valid", bus.rsp_valid_o, 0);

    // contention: both held, 4 writes then 1 lookup, repeating
    cyc();
    bus.write_req_i = 1'b1; bus.write_addr_i = 7'd20; bus.write_set_i = 4'b0001;
    bus.write_data_i = 32'hC0DE_0000;
    bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 7'd20; bus.lookup_set_i = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gl[i] = bus.lookup_gnt_o;
      gw[i] = bus.write_gnt_o;
    end
    chk("cont_lookup_pattern", gl, 10'b10_0001_0000);
    chk("cont_write_pattern", gw, 10'b01_1110_1111);
    cyc();
    bus.write_req_i = 1'b0; bus.lookup_req_i = 1'b0;

    // same-address collision: forced lookup returns pre-write content
    cyc();
    bus.write_req_i = 1'b1; bus.write_addr_i = 7'd3; bus.write_set_i = 4'b0100;
    bus.write_data_i = 32'h0000_000A;
    @(negedge clk);
    chk("col_seed_write", bus.write_gnt_o, 1);
    cyc();
    bus.write_addr_i = 7'd10; bus.write_data_i = 32'h0000_0055;
    bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 7'd3; bus.lookup_set_i = 2'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("col_starve_write", bus.write_gnt_o, 1);
      chk("col_starve_lookup", bus.lookup_gnt_o, 0);
      cyc();
    end
    bus.write_addr_i = 7'd3; bus.write_data_i = 32'h0000_000B;
    @(negedge clk);
    chk("col_forced_lookup", bus.lookup_gnt_o, 1);
    chk("col_forced_no_write", bus.write_gnt_o, 0);
    cyc();
    bus.lookup_req_i = 1'b0;
    @(negedge clk);
    chk("col_write_after", bus.write_gnt_o, 1);
    chk("col_rsp_old", bus.rsp_data_o, 32'h0000_000A);
    cyc();
    bus.write_req_i = 1'b0;
    bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 7'd3; bus.lookup_set_i = 2'd2;
    @(negedge clk);
    chk("col_reread_gnt", bus.lookup_gnt_o, 1);
    cyc();
    bus.lookup_req_i = 1'b0;
    @(negedge clk);
    chk("col_rsp_new", bus.rsp_data_o, 32'h0000_000B);

    // reset in the cycle after a grant discards the response
    cyc();
    bus.lookup_req_i = 1'b1; bus.lookup_addr_i = 7'd1; bus.lookup_set_i = 2'd0;
    @(negedge clk);
    chk("rr_gnt", bus.lookup_gnt_o, 1);
    cyc();
    rst_ni = 1'b0;
    bus.lookup_req_i = 1'b0;
    @(negedge clk);
    chk("rr_valid_in_reset", bus.rsp_valid_o, 0);
    cyc();
    cyc();
    rst_ni = 1'b1;
    wait_init();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_no_pulse", bus.rsp_valid_o, 0);
    end
  endtask

  initial begin
    bus.lookup_req_i  = 1'b0;
    bus.lookup_addr_i = '0;
    bus.lookup_set_i  = '0;
    bus.rsp_ready_i   = 1'b1;
    bus.write_req_i   = 1'b0;
    bus.write_addr_i  = '0;
    bus.write_set_i   = '0;
    bus.write_data_i  = '0;
    fork
      compare_loop();
      directed();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
